// File: rtl/apb_pkg.sv
// Shared APB definitions used by the responder, initiator and delayer blocks.
//   APB_AW / APB_DW / APB_SW : address, data and strobe widths
//   resp_state_e             : responder FSM encoding (IDLE=0, WAIT=1, RESP=2)
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/apb_bytemem.sv
// Word-organised memory with per-byte write enables.
// Synchronous write on posedge clock, asynchronous (combinational) read.
//   clock  in  1                 write clock
//   we     in  1                 write enable
//   addr   in  $clog2(DEPTH)     word index, shared by read and write
//   wdata  in  APB_DW            write data
//   wstrb  in  APB_SW            byte enables; bit i -> wdata[8i+7:8i]
//   rdata  out APB_DW            contents of the word at addr
module apb_bytemem
  import apb_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [APB_DW-1:0] wdata,
  input  logic [APB_SW-1:0] wstrb,
  output logic [APB_DW-1:0] rdata
);

  logic [APB_DW-1:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset branch on purpose; resetting a memory turns
  // it into thousands of flops instead of an SRAM macro or LUT-RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < APB_SW; b++) begin
        if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_sram_responder.sv
// APB completer terminating transfers on a word SRAM with WAIT_CYCLES wait
// states. Out-of-range or misaligned accesses complete with pslverr.
//   clock, reset         single clock, synchronous active-high reset
//   in_paddr/psel/penable/pprot/pwrite/pwdata/pstrb   APB request (pprot ignored)
//   in_pready/prdata/pslverr                          APB response, registered;
//                                                     all zero outside the RESP cycle
module apb_sram_responder
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                DEPTH_WORDS = 256,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [APB_AW-1:0] in_paddr,
  input  logic              in_psel,
  input  logic              in_penable,
  input  logic [2:0]        in_pprot,
  input  logic              in_pwrite,
  input  logic [APB_DW-1:0] in_pwdata,
  input  logic [APB_SW-1:0] in_pstrb,
  output logic              in_pready,
  output logic [APB_DW-1:0] in_prdata,
  output logic              in_pslverr
);

  localparam int                IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [APB_AW-1:0] SPAN      = APB_AW'(DEPTH_WORDS * 4);
  localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES);

  // Decode. The subtraction wraps in 32 bits, so addresses below BASE_ADDR
  // become huge offsets and miss.
  logic [APB_AW-1:0] offset;
  logic              hit, aligned, err, access;
  logic [IDX_W-1:0]  idx;

  assign offset  = in_paddr - BASE_ADDR;
  assign hit     = offset < SPAN;
  assign aligned = in_paddr[1:0] == 2'b00;
  assign err     = !hit || !aligned;
  assign idx     = offset[IDX_W+1:2];
  assign access  = in_psel && in_penable;

  logic unused_pprot;
  assign unused_pprot = ^in_pprot;

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        enter_resp;

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          cnt_d = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!access) begin
          // Initiator abandoned the transfer: no response, no write.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic              pready_q, pslverr_q, commit_q;
  logic [APB_DW-1:0] prdata_q, mem_rdata;
  logic [IDX_W-1:0]  wr_idx_q;
  logic [APB_DW-1:0] wr_data_q;
  logic [APB_SW-1:0] wr_strb_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= enter_resp;
      if (enter_resp) begin
        prdata_q  <= (!in_pwrite && !err) ? mem_rdata : '0;
        pslverr_q <= err;
        commit_q  <= in_pwrite && !err;
      end else begin
        prdata_q  <= '0;
        pslverr_q <= 1'b0;
        commit_q  <= 1'b0;
      end
    end
  end

  // Write payload captured with the response; only qualified by commit_q.
  always_ff @(posedge clock) begin
    if (enter_resp) begin
      wr_idx_q  <= idx;
      wr_data_q <= in_pwdata;
      wr_strb_q <= in_pstrb;
    end
  end

  // Commit lands on the edge that ends RESP; reset in that cycle drops it.
  apb_bytemem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clock (clock),
    .we    (commit_q && !reset),
    .addr  (commit_q ? wr_idx_q : idx),
    .wdata (wr_data_q),
    .wstrb (wr_strb_q),
    .rdata (mem_rdata)
  );

  assign in_pready  = pready_q;
  assign in_prdata  = prdata_q;
  assign in_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_sram_responder.sv
// Scoreboard bench: dut has WAIT_CYCLES=2, dut0 has WAIT_CYCLES=0. They share
// every request signal except psel, so only the selected one sees a transfer.
module tb_apb_sram_responder;
  import apb_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clock, reset;
  logic [31:0] paddr, pwdata;
  logic        psel2, psel0, penable, pwrite;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic        pready2, pslverr2, pready0, pslverr0;
  logic [31:0] prdata2, prdata0;

  apb_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel2),
    .in_penable(penable), .in_pprot(pprot), .in_pwrite(pwrite),
    .in_pwdata(pwdata), .in_pstrb(pstrb), .in_pready(pready2),
    .in_prdata(prdata2), .in_pslverr(pslverr2));

  apb_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel0),
    .in_penable(penable), .in_pprot(pprot), .in_pwrite(pwrite),
    .in_pwdata(pwdata), .in_pstrb(pstrb), .in_pready(pready0),
    .in_prdata(prdata0), .in_pslverr(pslverr0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [2][256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered and left at #1 after a posedge, so consecutive calls are back-to-back.
  task automatic apb_xfer(input int sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input string tag);
    exp_t        e;
    logic [31:0] off;
    logic        err;
    int          idx, cycles;
    bit          done;
    logic [31:0] got_rdata;
    logic        got_err;
    off    = addr - BASE;
    err    = !(off < 32'd1024) || (addr[1:0] != 2'b00);
    idx    = int'(off[9:2]);
    e.err    = err;
    e.rdata  = (wr || err) ? 32'h0 : model[sel][idx];
    e.cycles = (sel != 0) ? 2 : 4;
    if (wr && !err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[sel][idx][8*b +: 8] = wdata[8*b +: 8];
    sb_q.push_back(e);

    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = 3'b010;
    penable = 1'b0;
    if (sel != 0) psel0 = 1'b1; else psel2 = 1'b1;
    @(posedge clock); #1 penable = 1'b1;

    cycles = 0; done = 0; got_rdata = '0; got_err = 1'b0;
    while (!done && cycles < 40) begin
      @(negedge clock);
      cycles++;
      if ((sel != 0) ? pready0 : pready2) begin
        done      = 1;
        got_rdata = (sel != 0) ? prdata0 : prdata2;
        got_err   = (sel != 0) ? pslverr0 : pslverr2;
      end else begin
        @(posedge clock); #1;
      end
    end
    e = sb_q.pop_front();
    check({tag, "_cycles"}, 32'(cycles), 32'(e.cycles));
    if (done) begin
      check({tag, "_rdata"}, got_rdata, e.rdata);
      check({tag, "_pslverr"}, 32'(got_err), 32'(e.err));
    end
    @(posedge clock); #1;
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; psel2 = 0; psel0 = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_pready",  32'(pready2),  32'h0);
    check("rst_prdata",  prdata2,       32'h0);
    check("rst_pslverr", 32'(pslverr2), 32'h0);
    check("rst_pready0", 32'(pready0),  32'h0);
    @(posedge clock); #1 reset = 1'b0;

    // Full-word write then read, then a single-byte merge.
    apb_xfer(0, 1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, "t1_wr");
    apb_xfer(0, 0, 32'h1000_0010, 32'h0,         4'h0, "t1_rd");
    apb_xfer(0, 1, 32'h1000_0010, 32'h0000_AA00, 4'h2, "t2_wr");
    apb_xfer(0, 0, 32'h1000_0010, 32'h0,         4'h0, "t2_rd");
    // Zero strobe: OKAY, memory untouched.
    apb_xfer(0, 1, 32'h1000_0010, 32'h1111_1111, 4'h0, "strb0_wr");
    apb_xfer(0, 0, 32'h1000_0010, 32'h0,         4'h0, "strb0_rd");

    // Range edges and error responses.
    apb_xfer(0, 1, 32'h1000_03FC, 32'hA5A5_5A5A, 4'hF, "last_wr");
    apb_xfer(0, 0, 32'h1000_03FC, 32'h0,         4'h0, "last_rd");
    apb_xfer(0, 0, 32'h1000_0400, 32'h0,         4'h0, "oor_rd");
    apb_xfer(0, 0, 32'h1000_0011, 32'h0,         4'h0, "misal_rd");
    apb_xfer(0, 1, 32'h0FFF_FFFC, 32'hFFFF_FFFF, 4'hF, "below_wr");
    apb_xfer(0, 1, 32'h1000_0412, 32'hFFFF_FFFF, 4'hF, "oor_wr");
    apb_xfer(0, 0, 32'h1000_0000, 32'h0,         4'h0, "w0_rd_pre");
    apb_xfer(0, 0, 32'h1000_0010, 32'h0,         4'h0, "t3_rd_unchanged");

    // Zero-wait build, back-to-back write/read pairs.
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1, 1, 32'h1000_0100 + 32'(4*i), $urandom, 4'hF, "b2b0_wr");
      apb_xfer(1, 0, 32'h1000_0100 + 32'(4*i), 32'h0,    4'h0, "b2b0_rd");
    end
    apb_xfer(1, 0, 32'h1000_0401, 32'h0, 4'h0, "b2b0_err");
    for (int i = 0; i < 3; i++) begin
      apb_xfer(0, 1, 32'h1000_0200 + 32'(4*i), $urandom, 4'hF, "b2b2_wr");
      apb_xfer(0, 0, 32'h1000_0200 + 32'(4*i), 32'h0,    4'h0, "b2b2_rd");
    end

    // Abort: psel dropped in access cycle 2 of a write.
    apb_xfer(0, 1, 32'h1000_0020, 32'hCAFE_F00D, 4'hF, "abort_pre");
    paddr = 32'h1000_0020; pwrite = 1; pwdata = 32'h1234_5678; pstrb = 4'hF;
    psel2 = 1; penable = 0;
    @(posedge clock); #1 penable = 1;
    @(negedge clock);
    check("abort_c1_pready", 32'(pready2), 32'h0);
    @(posedge clock); #1 psel2 = 0; penable = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_pready", 32'(pready2), 32'h0);
    end
    @(posedge clock); #1;
    apb_xfer(0, 0, 32'h1000_0020, 32'h0, 4'h0, "abort_rd");

    // Reset in the last WAIT cycle of a write.
    apb_xfer(0, 1, 32'h1000_0030, 32'h5555_AAAA, 4'hF, "rstw_pre");
    paddr = 32'h1000_0030; pwrite = 1; pwdata = 32'hFFFF_0000; pstrb = 4'hF;
    psel2 = 1; penable = 0;
    @(posedge clock); #1 penable = 1;
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 psel2 = 0; penable = 0;
    @(negedge clock);
    check("rstw_pready",  32'(pready2),  32'h0);
    check("rstw_prdata",  prdata2,       32'h0);
    check("rstw_pslverr", 32'(pslverr2), 32'h0);
    check("rstw_state",   32'(dut.state_q), 32'(IDLE));
    @(posedge clock); #1 reset = 0;
    apb_xfer(0, 0, 32'h1000_0030, 32'h0, 4'h0, "rstw_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
